mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive data grants allowed while a fetch waits.
REQ-002 SHALL have CLK  input  1  clock, rising-edge active.
REQ-003 SHALL have nRST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have iREN  input  1  instruction fetch request.
REQ-005 SHALL have iaddr  input  32  fetch word address.
REQ-006 SHALL have halt  input  1  processor halted; suppresses new fetch grants.
REQ-007 SHALL have dREN, dWEN  input  1 each  data read and data write requests.
REQ-008 SHALL have daddr, dstore  input  32 each  data address and write data.
REQ-009 SHALL have ihit, dhit  output  1 each  one-cycle completion pulses to the pipeline latches.
REQ-010 SHALL have iload, dload  output  32 each  returned instruction and returned read data.
REQ-011 SHALL have ramREN, ramWEN  output  1 each  single shared memory port strobes.
REQ-012 SHALL have ramaddr, ramstore  output  32 each  memory port address and write data.
REQ-013 SHALL have ramload  input  32  memory read data.
REQ-014 SHALL have ram_ready  input  1  access complete this cycle.

Function
REQ-015 SHALL implement the FSM states IDLE, IFETCH and DACCESS.
REQ-016 IDLE SHALL evaluate requests each cycle; the chosen access is latched (address, store data, type) on the transition edge.
REQ-017 Priority SHALL be: data (dREN|dWEN) over fetch (iREN & !halt), except when starve_cnt == STARVE_MAX, where fetch wins.
REQ-018 With dREN and dWEN both high, the access SHALL be a write; ramREN and ramWEN SHALL never both be 1.
REQ-019 In IFETCH/DACCESS, ramREN/ramWEN/ramaddr/ramstore SHALL be driven from latched registers; in IDLE all SHALL be 0.
REQ-020 On ram_ready in IFETCH: ihit=1 for that cycle only if iREN is still high, and iload=ramload; next state IDLE.
REQ-021 On ram_ready in DACCESS: dhit=1 for that cycle if the request is still high (writes always), and dload=ramload on reads; next state IDLE.
REQ-022 An access SHALL always run to ram_ready once started; a request dropped mid-access (flush) completes silently with no hit.
REQ-023 Minimum latency SHALL be 2 cycles (request seen in IDLE -> hit in the following cycle with ram_ready=1); each grant returns through IDLE for one cycle.
REQ-024 starve_cnt (3 bits) SHALL increment on each data grant while iREN & !halt, saturate at STARVE_MAX, and clear on a fetch grant or whenever iREN=0 or halt=1 in IDLE.
REQ-025 ihit and dhit SHALL never assert in the same cycle; iload/dload SHALL be combinational and valid only with their hit.
REQ-026 With halt=1, fetch SHALL not be granted, while data accesses (e.g. dump writes) SHALL still be serviced; a fetch already in progress completes.

Reset
REQ-027 While nRST=0: state=IDLE, starve_cnt=0, latched address/data/type=0, and all outputs 0 (ihit, dhit, ramREN, ramWEN, ramaddr, ramstore, iload, dload).
REQ-028 Reset asserted mid-access SHALL abort the access immediately with no hit; after release, arbitration restarts from IDLE.

Verification
REQ-029 Fetch only: iREN=1, iaddr=0x100, ram_ready=1 with ramload=0xDEADBEEF the cycle after grant -> ramREN=1, ramaddr=0x100, ihit=1, iload=0xDEADBEEF; ramREN=0 the next cycle.
REQ-030 Simultaneous iREN and dREN (daddr=0x200) -> data served first (ramaddr=0x200, dhit); fetch granted on the next IDLE.
REQ-031 Starvation: iREN held, dREN held for 6 accesses, STARVE_MAX=4 -> grants D,D,D,D,I,D; starve_cnt returns to 0 after I.
REQ-032 Write with dREN=dWEN=1, daddr=0x40, dstore=0x1234 -> ramWEN=1, ramREN=0, ramstore=0x1234, dhit on ram_ready.
REQ-033 Flush: iREN dropped while ram_ready is held low for 3 cycles -> FSM stays in IFETCH, completes on ram_ready, ihit=0, then IDLE.
REQ-034 Halt/reset: halt=1 with iREN=1 -> no fetch grant; nRST pulsed during DACCESS -> all outputs 0 immediately and no dhit.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction fetches and data accesses onto one shared memory port.
// Ports:
//   CLK, nRST            clock (rising edge) and asynchronous active-low reset
//   iREN, iaddr, halt    fetch request, fetch address, halt (suppresses new fetch grants)
//   dREN, dWEN, daddr,   data read/write requests, address and write data
//   dstore
//   ihit, iload          fetch completion pulse and returned instruction
//   dhit, dload          data completion pulse and returned read data
//   ramREN, ramWEN,      shared memory port strobes, address and write data
//   ramaddr, ramstore
//   ramload, ram_ready   memory read data and access-complete indication
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        halt,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] IFETCH  = 2'd1;
  localparam logic [1:0] DACCESS = 2'd2;
  localparam logic [2:0] SMAX    = 3'(STARVE_MAX);

  logic [1:0]  state_q, state_d;
  logic [2:0]  starve_q, starve_d;
  logic [31:0] addr_q, addr_d, store_q, store_d;
  logic        wen_q, wen_d;
  logic        fetch_req, data_req, grant_i, grant_d, busy;

  always_comb begin
    fetch_req = iREN & ~halt;
    data_req  = dREN | dWEN;
    // data normally wins; a fetch that has waited STARVE_MAX data grants takes priority
    grant_i   = (state_q == IDLE) & fetch_req & (~data_req | (starve_q == SMAX));
    grant_d   = (state_q == IDLE) & data_req & ~grant_i;
    state_d   = state_q;
    starve_d  = starve_q;
    addr_d    = addr_q;
    store_d   = store_q;
    wen_d     = wen_q;
    if (state_q == IDLE) begin
      starve_d = (~fetch_req | grant_i) ? 3'd0 :
                 (grant_d & (starve_q != SMAX)) ? starve_q + 3'd1 : starve_q;
      if (grant_i | grant_d) begin
        state_d = grant_i ? IFETCH : DACCESS;
        addr_d  = grant_i ? iaddr : daddr;
        // dREN & dWEN together is treated as a write
        wen_d   = grant_d & dWEN;
        store_d = (grant_d & dWEN) ? dstore : 32'd0;
      end
    end else if (ram_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      starve_q <= 3'd0;
      addr_q   <= 32'd0;
      store_q  <= 32'd0;
      wen_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      wen_q    <= wen_d;
    end
  end

  // a dropped request still runs to ram_ready but produces no hit
  assign busy     = state_q != IDLE;
  assign ramREN   = (state_q == IFETCH) | ((state_q == DACCESS) & ~wen_q);
  assign ramWEN   = (state_q == DACCESS) & wen_q;
  assign ramaddr  = busy ? addr_q : 32'd0;
  assign ramstore = busy ? store_q : 32'd0;
  assign ihit     = (state_q == IFETCH) & ram_ready & iREN;
  assign dhit     = (state_q == DACCESS) & ram_ready & (wen_q | dREN);
  assign iload    = ihit ? ramload : 32'd0;
  assign dload    = (dhit & ~wen_q) ? ramload : 32'd0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
  localparam int SMAX = 4;
  logic        CLK = 0, nRST = 0;
  logic        iREN = 0, halt = 0, dREN = 0, dWEN = 0, ram_ready = 0;
  logic [31:0] iaddr = 0, daddr = 0, dstore = 0, ramload = 0;
  logic        ihit, dhit, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;
  int          passed = 0, total = 0;

  mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .halt(halt),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  // Transaction-level model: either no access is outstanding, or one access
  // (fetch or data read/write) is in flight until memory reports ready.
  bit          m_busy, m_fetch, m_write;
  logic [31:0] m_addr, m_store;
  int          m_starve;
  logic        e_ir, e_iw, e_ih, e_dh;
  logic [31:0] e_ra, e_rs, e_il, e_dl;

  always @(negedge CLK) begin
    {e_ir, e_iw, e_ih, e_dh, e_ra, e_rs, e_il, e_dl} = '0;
    if (!nRST) begin
      m_busy = 0;
      m_starve = 0;
    end else if (m_busy) begin
      e_ir = m_fetch || !m_write;
      e_iw = !m_fetch && m_write;
      e_ra = m_addr;
      e_rs = m_store;
      e_ih = m_fetch && ram_ready && iREN;
      e_dh = !m_fetch && ram_ready && (m_write || dREN);
      e_il = e_ih ? ramload : 0;
      e_dl = (e_dh && !m_write) ? ramload : 0;
      if (ram_ready) m_busy = 0;
    end else begin
      bit want_i, want_d, take_i;
      want_i = iREN && !halt;
      want_d = dREN || dWEN;
      take_i = want_i && (!want_d || m_starve >= SMAX);
      if (!want_i || take_i) m_starve = 0;
      else if (m_starve < SMAX) m_starve++;
      if (take_i || want_d) begin
        m_busy  = 1;
        m_fetch = take_i;
        m_write = !take_i && dWEN;
        m_addr  = take_i ? iaddr : daddr;
        m_store = m_write ? dstore : 0;
      end
    end
    chk("ramREN", ramREN, e_ir);
    chk("ramWEN", ramWEN, e_iw);
    chk("ramaddr", ramaddr, e_ra);
    chk("ramstore", ramstore, e_rs);
    chk("ihit", ihit, e_ih);
    chk("dhit", dhit, e_dh);
    chk("iload", iload, e_il);
    chk("dload", dload, e_dl);
    chk("hit_excl", ihit && dhit, 1'b0);
    chk("strobe_excl", ramREN && ramWEN, 1'b0);
  end

  logic [47:0] seq;

  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_outs", {ihit, dhit, ramREN, ramWEN, ramaddr | ramstore | iload | dload}, '0);
    nxt();
    nRST = 1;
    // fetch only
    iREN = 1; iaddr = 32'h100; ram_ready = 1; ramload = 32'hDEADBEEF;
    @(negedge CLK) chk("f_idle_ren", ramREN, 1'b0);
    nxt();
    @(negedge CLK);
    chk("f_ren", ramREN, 1'b1);
    chk("f_addr", ramaddr, 32'h100);
    chk("f_ihit", ihit, 1'b1);
    chk("f_iload", iload, 32'hDEADBEEF);
    nxt();
    iREN = 0;
    @(negedge CLK) chk("f_after_ren", ramREN, 1'b0);
    // simultaneous fetch and data: data first
    nxt();
    iREN = 1; dREN = 1; daddr = 32'h200; ramload = 32'h55;
    nxt();
    @(negedge CLK);
    chk("pri_addr", ramaddr, 32'h200);
    chk("pri_dhit", dhit, 1'b1);
    chk("pri_dload", dload, 32'h55);
    nxt();
    dREN = 0;
    nxt();
    @(negedge CLK);
    chk("pri_faddr", ramaddr, 32'h100);
    chk("pri_ihit", ihit, 1'b1);
    nxt();
    iREN = 0;
    // starvation: D,D,D,D,I,D
    nxt();
    iREN = 1; iaddr = 32'h300; dREN = 1; daddr = 32'h200; seq = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (ramREN || ramWEN) seq = {seq[39:0], (ramaddr == 32'h300) ? "I" : "D"};
      nxt();
    end
    chk("starve_seq", seq, "DDDDID");
    iREN = 0; dREN = 0;
    // write with both strobes
    nxt();
    dREN = 1; dWEN = 1; daddr = 32'h40; dstore = 32'h1234;
    nxt();
    @(negedge CLK);
    chk("w_wen", ramWEN, 1'b1);
    chk("w_ren", ramREN, 1'b0);
    chk("w_store", ramstore, 32'h1234);
    chk("w_dhit", dhit, 1'b1);
    nxt();
    dREN = 0; dWEN = 0;
    // flush: fetch dropped while memory stalls
    nxt();
    iREN = 1; iaddr = 32'h500; ram_ready = 0;
    nxt();
    iREN = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK) chk("fl_stall", {ramREN, ramaddr}, {1'b1, 32'h500});
      nxt();
    end
    ram_ready = 1;
    @(negedge CLK) chk("fl_done", {ramREN, ihit}, 2'b10);
    nxt();
    @(negedge CLK) chk("fl_idle", ramREN, 1'b0);
    // halt blocks fetch, dump write still serviced, reset aborts it
    nxt();
    halt = 1; iREN = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK) chk("halt_nofetch", ramREN, 1'b0);
      nxt();
    end
    dWEN = 1; daddr = 32'h60; dstore = 32'hABCD; ram_ready = 0;
    nxt();
    @(negedge CLK) chk("halt_dump", {ramWEN, ramaddr}, {1'b1, 32'h60});
    nxt();
    ram_ready = 1;
    nRST = 0;
    #1 chk("rst_abort", {ihit, dhit, ramREN, ramWEN, ramaddr | ramstore | iload | dload}, '0);
    @(negedge CLK) chk("rst_nodhit", dhit, 1'b0);
    nxt();
    nRST = 1; halt = 0; iREN = 0; dWEN = 0;
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      nxt();
      iREN = $urandom_range(0, 3) != 0;
      dREN = $urandom_range(0, 2) == 0;
      dWEN = $urandom_range(0, 4) == 0;
      halt = $urandom_range(0, 9) == 0;
      ram_ready = $urandom_range(0, 2) != 0;
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      nRST = $urandom_range(0, 199) != 0;
    end
    nxt();
    nRST = 1;
    repeat (2) @(negedge CLK);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
